alarm_entry_ctrl: RTL and testbench

//  Keypad entry controller for the alarm clock: collects four BCD digits (HH:MM) from the

---
 rtl/alarm_clock_pkg.sv | 50 +++++
 rtl/alarm_entry_ctrl_if.sv | 39 +++
 rtl/alarm_entry_timeout.sv | 39 +++
 rtl/alarm_entry_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alarm_entry_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alarm_clock_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_clock_pkg
// Description : Shared types and constants for the alarm clock: entry FSM
//               state encoding, commit target encoding, digit range limits,
//               and the HH:MM range test used when ENTRY_RANGE_CHECK_EN is
//               defined.
// Revision    : 1.0  initial release
// ============================================================================
package alarm_clock_pkg;

    // Entry controller FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } entry_state_t;

    // Which register a finished entry is committed to
    typedef enum logic {
        TGT_ALARM = 1'b0,
        TGT_TIME  = 1'b1
    } entry_target_t;

    localparam logic [3:0] KEY_MAX_DIGIT    = 4'd9;
    localparam logic [3:0] MAX_MS_HR        = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_2   = 4'd3;
    localparam logic [3:0] MAX_MS_MIN       = 4'd5;
    localparam logic [2:0] DIGIT_COUNT_FULL = 3'd4;

    // True when the entered digits form a legal 24-hour time (00:00-23:59)
    function automatic logic entry_time_valid(
        input logic [3:0] ms_hr,
        input logic [3:0] ls_hr,
        input logic [3:0] ms_min
    );
        logic w_hr_ok;
        if (ms_hr < MAX_MS_HR) begin
            w_hr_ok = (ls_hr <= KEY_MAX_DIGIT);
        end else if (ms_hr == MAX_MS_HR) begin
            w_hr_ok = (ls_hr <= MAX_LS_HR_AT_2);
        end else begin
            w_hr_ok = 1'b0;
        end
        return w_hr_ok && (ms_min <= MAX_MS_MIN);
    endfunction

endpackage : alarm_clock_pkg
`default_nettype wire

// File: rtl/alarm_entry_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_entry_ctrl_if
// Description : Keypad/button inputs and entry-result outputs of the alarm
//               entry controller. The master modport is the controller side;
//               the slave modport is the keypad/register environment side.
// Revision    : 1.0  initial release
// ============================================================================
interface alarm_entry_ctrl_if;

    logic [3:0] key;
    logic       key_valid;
    logic       alarm_button;
    logic       time_button;
    logic       one_second;
    logic [3:0] new_ms_hr;
    logic [3:0] new_ls_hr;
    logic [3:0] new_ms_min;
    logic [3:0] new_ls_min;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       show_new_time;
    logic       entry_error;

    modport master (
        input  key, key_valid, alarm_button, time_button, one_second,
        output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        output load_new_alarm, load_new_time, show_new_time, entry_error
    );

    modport slave (
        output key, key_valid, alarm_button, time_button, one_second,
        input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
        input  load_new_alarm, load_new_time, show_new_time, entry_error
    );

endinterface : alarm_entry_ctrl_if
`default_nettype wire

// File: rtl/alarm_entry_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_entry_timeout
// Description : Counts enable ticks since the last clear; expired pulses on
//               the tick that brings the count to TIMEOUT_SEC. Clear has
//               priority over a simultaneous tick.
// Revision    : 1.0  initial release
// ============================================================================
module alarm_entry_timeout #(
    parameter int TIMEOUT_SEC = 10
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  clear,
    input  wire  enable,
    output logic expired
);

    localparam int C_CNT_W = $clog2(TIMEOUT_SEC + 1);

    logic [C_CNT_W-1:0] r_count;

    // Expire on the tick that would make the count reach TIMEOUT_SEC
    assign expired = enable && !clear && (r_count == C_CNT_W'(TIMEOUT_SEC - 1));

    // Tick counter, restarted by clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count < C_CNT_W'(TIMEOUT_SEC))) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : alarm_entry_timeout
`default_nettype wire

// File: rtl/alarm_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_entry_ctrl
// Description : Keypad entry controller. Collects four BCD digits (HH:MM)
//               after an alarm/time button opens an entry, and commits them
//               with a one-cycle load strobe when the same button is pressed
//               again. Short entries are rejected with entry_error; an idle
//               entry is abandoned after TIMEOUT_SEC one_second ticks.
//               Optional macro ENTRY_RANGE_CHECK_EN: commit also requires the
//               digits to be a legal 00:00-23:59 time.
// Revision    : 1.0  initial release
// ============================================================================
module alarm_entry_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 10
) (
    input  wire                 clock,
    input  wire                 reset,
    alarm_entry_ctrl_if.master  bus
);

    entry_state_t  r_state;
    entry_state_t  w_state_next;
    entry_target_t r_target;
    logic [3:0]    r_ms_hr;
    logic [3:0]    r_ls_hr;
    logic [3:0]    r_ms_min;
    logic [3:0]    r_ls_min;
    logic [2:0]    r_count;
    logic          r_entry_error;

    logic w_digit_key;
    logic w_commit_btn;
    logic w_range_ok;
    logic w_accept;
    logic w_open;
    logic w_shift;
    logic w_clear_digits;
    logic w_reject;
    logic w_to_clear;
    logic w_to_enable;
    logic w_expired;

    assign w_digit_key  = bus.key_valid && (bus.key <= KEY_MAX_DIGIT);
    assign w_commit_btn = (r_target == TGT_ALARM) ? bus.alarm_button : bus.time_button;

`ifdef ENTRY_RANGE_CHECK_EN
    assign w_range_ok = entry_time_valid(r_ms_hr, r_ls_hr, r_ms_min);
`else
    assign w_range_ok = 1'b1;
`endif

    assign w_accept = (r_count == DIGIT_COUNT_FULL) && w_range_ok;

    // The timeout restarts outside ENTRY and on every accepted digit key
    assign w_to_clear  = (r_state != ST_ENTRY) || w_digit_key;
    assign w_to_enable = bus.one_second && (r_state == ST_ENTRY);

    alarm_entry_timeout #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_to_clear),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; a commit button outranks a key
    // arriving in the same cycle, and a digit key outranks a timeout
    always_comb begin
        w_state_next   = r_state;
        w_open         = 1'b0;
        w_shift        = 1'b0;
        w_clear_digits = 1'b0;
        w_reject       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.alarm_button || bus.time_button) begin
                    w_state_next = ST_ENTRY;
                    w_open       = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (w_commit_btn) begin
                    if (w_accept) begin
                        w_state_next = ST_COMMIT;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_reject       = 1'b1;
                        w_clear_digits = 1'b1;
                    end
                end else if (w_digit_key) begin
                    w_shift = 1'b1;
                end else if (w_expired) begin
                    w_state_next   = ST_IDLE;
                    w_clear_digits = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Commit target latched when an entry opens; alarm wins a tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_target <= TGT_ALARM;
        end else if (w_open) begin
            r_target <= bus.alarm_button ? TGT_ALARM : TGT_TIME;
        end
    end

    // Digit shift register and saturating digit count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ms_hr  <= '0;
            r_ls_hr  <= '0;
            r_ms_min <= '0;
            r_ls_min <= '0;
            r_count  <= '0;
        end else if (w_open || w_clear_digits) begin
            r_ms_hr  <= '0;
            r_ls_hr  <= '0;
            r_ms_min <= '0;
            r_ls_min <= '0;
            r_count  <= '0;
        end else if (w_shift) begin
            r_ms_hr  <= r_ls_hr;
            r_ls_hr  <= r_ms_min;
            r_ms_min <= r_ls_min;
            r_ls_min <= bus.key;
            if (r_count != DIGIT_COUNT_FULL) begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    // One-cycle rejection strobe, issued as the FSM drops back to IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_entry_error <= 1'b0;
        end else begin
            r_entry_error <= w_reject;
        end
    end

    assign bus.new_ms_hr      = r_ms_hr;
    assign bus.new_ls_hr      = r_ls_hr;
    assign bus.new_ms_min     = r_ms_min;
    assign bus.new_ls_min     = r_ls_min;
    assign bus.load_new_alarm = (r_state == ST_COMMIT) && (r_target == TGT_ALARM);
    assign bus.load_new_time  = (r_state == ST_COMMIT) && (r_target == TGT_TIME);
    assign bus.show_new_time  = (r_state == ST_ENTRY);
    assign bus.entry_error    = r_entry_error;

endmodule : alarm_entry_ctrl
`default_nettype wire

// File: tb/tb_alarm_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alarm_entry_ctrl
// Description : Directed self-checking bench for alarm_entry_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_entry_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clock = ~clock;

    alarm_entry_ctrl_if bus ();

    alarm_entry_ctrl #(
        .TIMEOUT_SEC (10)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_alarm();
        bus.alarm_button = 1'b1;
        step();
        bus.alarm_button = 1'b0;
    endtask

    task automatic pulse_time();
        bus.time_button = 1'b1;
        step();
        bus.time_button = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic tick_sec();
        bus.one_second = 1'b1;
        step();
        bus.one_second = 1'b0;
        step();
    endtask

    // Digits packed as HH:MM nibbles
    task automatic chk_digits(input string tag, input logic [15:0] exp);
        chk_eq(tag, {16'd0, bus.new_ms_hr, bus.new_ls_hr, bus.new_ms_min, bus.new_ls_min},
               {16'd0, exp});
    endtask

    // Strobes packed as {load_new_alarm, load_new_time, entry_error, show_new_time}
    task automatic chk_strobes(input string tag, input logic [3:0] exp);
        chk_eq(tag, {28'd0, bus.load_new_alarm, bus.load_new_time, bus.entry_error,
                     bus.show_new_time}, {28'd0, exp});
    endtask

    initial begin
        bus.key          = 4'd0;
        bus.key_valid    = 1'b0;
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
        bus.one_second   = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk_digits("reset_digits", 16'h0000);
        chk_strobes("reset_strobes", 4'b0000);
        reset = 1'b1;
        step();
        press_key(4'd7);
        chk_strobes("idle_key_ignored", 4'b0000);
        chk_digits("idle_key_digits", 16'h0000);

        // Alarm entry 07:30
        pulse_alarm();
        chk_strobes("t1_open", 4'b0001);
        press_key(4'd0);
        press_key(4'd7);
        press_key(4'd3);
        press_key(4'd0);
        chk_digits("t1_entry", 16'h0730);
        pulse_alarm();
        chk_strobes("t1_commit", 4'b1000);
        chk_digits("t1_commit_digits", 16'h0730);
        step();
        chk_strobes("t1_after", 4'b0000);
        chk_digits("t1_hold", 16'h0730);

        // Time entry with five digits; the wrong button is ignored mid-entry
        pulse_time();
        chk_digits("t2_open_clear", 16'h0000);
        press_key(4'd1);
        pulse_alarm();
        chk_strobes("t2_other_btn", 4'b0001);
        press_key(4'd2);
        press_key(4'd4);
        press_key(4'd5);
        press_key(4'd6);
        chk_digits("t2_entry", 16'h2456);
        pulse_time();
`ifdef ENTRY_RANGE_CHECK_EN
        chk_strobes("t2_commit", 4'b0010);
        chk_digits("t2_commit_digits", 16'h0000);
`else
        chk_strobes("t2_commit", 4'b0100);
        chk_digits("t2_commit_digits", 16'h2456);
`endif
        step();
        chk_strobes("t2_after", 4'b0000);

        // Short entry rejected
        pulse_alarm();
        press_key(4'd1);
        press_key(4'd2);
        chk_digits("t3_entry", 16'h0012);
        pulse_alarm();
        chk_strobes("t3_reject", 4'b0010);
        chk_digits("t3_cleared", 16'h0000);
        step();
        chk_strobes("t3_after", 4'b0000);

        // 24:00 -- out of range only when range checking is built in
        pulse_alarm();
        press_key(4'd2);
        press_key(4'd4);
        press_key(4'd0);
        press_key(4'd0);
        pulse_alarm();
`ifdef ENTRY_RANGE_CHECK_EN
        chk_strobes("t4_commit", 4'b0010);
        chk_digits("t4_digits", 16'h0000);
`else
        chk_strobes("t4_commit", 4'b1000);
        chk_digits("t4_digits", 16'h2400);
`endif
        step();

        // Timeout after 10 ticks; a non-digit key does not restart it
        pulse_alarm();
        press_key(4'd5);
        repeat (5) tick_sec();
        press_key(4'd12);
        chk_digits("t5_nondigit", 16'h0005);
        repeat (4) tick_sec();
        chk_strobes("t5_nine_ticks", 4'b0001);
        bus.one_second = 1'b1;
        step();
        bus.one_second = 1'b0;
        chk_strobes("t5_timeout", 4'b0000);
        chk_digits("t5_cleared", 16'h0000);
        step();
        chk_strobes("t5_idle", 4'b0000);

        // Commit button and digit key in the same cycle: key discarded
        pulse_alarm();
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        bus.key          = 4'd9;
        bus.key_valid    = 1'b1;
        bus.alarm_button = 1'b1;
        step();
        bus.key_valid    = 1'b0;
        bus.alarm_button = 1'b0;
        chk_strobes("t6_commit", 4'b1000);
        chk_digits("t6_digits", 16'h1234);
        step();

        // Reset in the middle of an entry
        pulse_alarm();
        press_key(4'd1);
        press_key(4'd2);
        chk_digits("t7_entry", 16'h0012);
        #2;
        reset = 1'b0;
        #1;
        chk_strobes("t7_reset_strobes", 4'b0000);
        chk_digits("t7_reset_digits", 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        chk_strobes("t7_after_reset", 4'b0000);
        pulse_time();
        chk_strobes("t7_reopen", 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_alarm_entry_ctrl
`default_nettype wire
